// File: rtl/fs_dither_stream.sv
// rtl/fs_dither_stream.sv - streaming Floyd-Steinberg error-diffusion quantiser
//
// Accepts raster-order pixels over valid/ready and emits OUT_BITS palette
// codes one cycle later. Error is diffused with a right-neighbour carry and
// a one-row signed error buffer.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dither_en                     1 = diffuse error, 0 = plain quantisation
//   in_valid/in_ready/in_pixel    input pixel stream
//   in_sof                        marks pixel (0,0), restarts the frame
//   out_valid/out_ready/out_code  output palette code stream
//   out_eol/out_eof               code closes its row / its frame
module fs_dither_stream #(
  parameter int PIX_W    = 8,
  parameter int OUT_BITS = 1,
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int ERR_W    = PIX_W + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dither_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIX_W-1:0]    in_pixel,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_code,
  output logic                out_eol,
  output logic                out_eof
);

  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int VW = ERR_W + 2;
  localparam int MW = ERR_W + 4;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGEY - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic signed [ERR_W-1:0] carry_q;
  // Partial next-row sums: nacc0_q holds e1 aimed at next-row entry x,
  // nacc1_q holds e1+e5 aimed at entry x-1; entry x-1 is completed by e3
  // of pixel x and only then written, so the current-row entry x is never
  // touched before it has been read.
  logic signed [ERR_W-1:0] nacc0_q;
  logic signed [ERR_W-1:0] nacc1_q;
  logic                    rb_valid_q;
  logic signed [ERR_W-1:0] rowbuf [IMAGEX];

  logic                    accept;
  logic [XW-1:0]           x_cur;
  logic [YW-1:0]           y_cur;
  logic                    first_col, last_col, last_row;
  logic signed [ERR_W-1:0] carry_in, row_in;
  logic signed [VW-1:0]    v;
  logic [PIX_W-1:0]        vs;
  logic [OUT_BITS-1:0]     code;
  logic [PIX_W-1:0]        recon;
  logic signed [ERR_W-1:0] e, e_d;
  logic signed [MW-1:0]    e_w, e7_p, e3_p, e5_p;
  logic signed [ERR_W-1:0] e7, e3, e5, e1;
  logic signed [ERR_W-1:0] e3_t, e5_t, e1_t, nacc0_eff;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // in_sof forces the pixel to (0,0) regardless of the counters.
  assign x_cur     = in_sof ? '0 : x_q;
  assign y_cur     = in_sof ? '0 : y_q;
  assign first_col = (x_cur == '0);
  assign last_col  = (x_cur == X_LAST);
  assign last_row  = (y_cur == Y_LAST);

  assign carry_in = (dither_en && !in_sof) ? carry_q : '0;
  assign row_in   = (dither_en && !in_sof && rb_valid_q && (y_cur != '0))
                    ? rowbuf[x_cur] : '0;

  assign v = $signed({{(VW-PIX_W){1'b0}}, in_pixel})
           + $signed({{(VW-ERR_W){carry_in[ERR_W-1]}}, carry_in})
           + $signed({{(VW-ERR_W){row_in[ERR_W-1]}}, row_in});

  always_comb begin
    vs = v[PIX_W-1:0];
    if (v[VW-1])
      vs = '0;
    else if (|v[VW-2:PIX_W])
      vs = '1;
  end

  assign code = vs[PIX_W-1 -: OUT_BITS];

  // Reconstruction level: code repeated MSB-first to fill PIX_W bits.
  always_comb begin
    recon = '0;
    for (int i = 0; i < PIX_W; i++)
      recon[PIX_W-1-i] = code[OUT_BITS-1-(i % OUT_BITS)];
  end

  assign e   = $signed({{(ERR_W-PIX_W){1'b0}}, vs}) - $signed({{(ERR_W-PIX_W){1'b0}}, recon});
  assign e_d = dither_en ? e : '0;
  assign e_w = {{(MW-ERR_W){e_d[ERR_W-1]}}, e_d};

  assign e7_p = (e_w <<< 3) - e_w;
  assign e3_p = (e_w <<< 1) + e_w;
  assign e5_p = (e_w <<< 2) + e_w;
  assign e7   = ERR_W'(e7_p >>> 4);
  assign e3   = ERR_W'(e3_p >>> 4);
  assign e5   = ERR_W'(e5_p >>> 4);
  // Remainder term keeps the four shares summing exactly to e.
  assign e1   = e_d - e7 - e3 - e5;

  assign e3_t      = (first_col || last_row) ? '0 : e3;
  assign e5_t      = last_row ? '0 : e5;
  assign e1_t      = (last_col || last_row) ? '0 : e1;
  assign nacc0_eff = first_col ? '0 : nacc0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      carry_q    <= '0;
      nacc0_q    <= '0;
      nacc1_q    <= '0;
      rb_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_code  <= code;
        out_eol   <= last_col;
        out_eof   <= last_col && last_row;
        carry_q   <= last_col ? '0 : e7;
        nacc1_q   <= nacc0_eff + e5_t;
        nacc0_q   <= e1_t;
        if (in_sof)
          rb_valid_q <= 1'b0;
        else if (last_col)
          rb_valid_q <= 1'b1;
        if (last_col) begin
          x_q <= '0;
          y_q <= last_row ? '0 : y_cur + YW'(1);
        end else begin
          x_q <= x_cur + XW'(1);
          y_q <= y_cur;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Buffer contents are qualified by rb_valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!first_col)
        rowbuf[x_cur - XW'(1)] <= nacc1_q + e3_t;
      if (last_col)
        rowbuf[x_cur] <= nacc0_eff + e5_t;
    end
  end

endmodule
